// File: rtl/mac_ctrl.sv
// mac_ctrl: sequencer for one signed multiply-accumulate datapath.
// Accepts a job configuration (vector length, vector count), consumes a
// stream of signed (x, k) pairs and emits one dot product per vector.
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both high. Ready may depend combinationally on the consumer's ready
// (s_ready_o follows m_ready_i), and a valid output is held with stable data
// until it is accepted.
//
// Ports:
//   clk_i, rst_ni              clock, synchronous active-low reset
//   cfg_valid_i/cfg_ready_o    configuration handshake (accepted only in IDLE)
//   cfg_len_i, cfg_num_i       products per dot product, dot products per job
//   s_valid_i/s_ready_o        operand pair handshake
//   s_x_i, s_k_i               signed operands
//   m_valid_o/m_ready_i        result handshake
//   m_data_o                   signed dot product (wraps modulo 2^WidthAcc)
//   busy_o                     high whenever the sequencer is not IDLE
//
// Pipeline: handshake -> beat register -> mul (MulLatency) -> acc
// (AccLatency) -> output register. The sideband {valid, first, last} travels
// alongside the data so the output register captures exactly when the final
// sum of a vector reaches the accumulator output.

module mac_ctrl_mul #(
  parameter int WidthX     = 4,
  parameter int WidthK     = 8,
  parameter int MulLatency = 1,
  parameter int WidthP     = WidthX + WidthK
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [WidthX-1:0] x_i,
  input  logic [WidthK-1:0] k_i,
  output logic [WidthP-1:0] p_o
);
  logic signed [WidthP-1:0] prod;
  logic [WidthP-1:0]        p_q [MulLatency];

  assign prod = WidthP'($signed(x_i)) * WidthP'($signed(k_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < MulLatency; i++) p_q[i] <= '0;
    end else if (en_i) begin
      p_q[0] <= prod;
      for (int i = 1; i < MulLatency; i++) p_q[i] <= p_q[i-1];
    end
  end

  assign p_o = p_q[MulLatency-1];
endmodule

module mac_ctrl_acc #(
  parameter int WidthP     = 12,
  parameter int WidthAcc   = 20,
  parameter int AccLatency = 1
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                en_i,
  input  logic                x_valid_i,
  input  logic                first_i,
  input  logic [WidthP-1:0]   x_i,
  output logic [WidthAcc-1:0] y_o
);
  logic [WidthAcc-1:0] ext;
  // Stage 0 is the accumulator itself; later stages only delay its value.
  logic [WidthAcc-1:0] d_q [AccLatency];

  assign ext = WidthAcc'($signed(x_i));

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      for (int i = 0; i < AccLatency; i++) d_q[i] <= '0;
    end else if (en_i) begin
      // A first beat restarts the sum so nothing carries over between vectors.
      if (x_valid_i) d_q[0] <= first_i ? ext : d_q[0] + ext;
      for (int i = 1; i < AccLatency; i++) d_q[i] <= d_q[i-1];
    end
  end

  assign y_o = d_q[AccLatency-1];
endmodule

module mac_ctrl #(
  parameter int WidthX     = 4,
  parameter int WidthK     = 8,
  parameter int WidthAcc   = 20,
  parameter int MulLatency = 1,
  parameter int AccLatency = 1,
  parameter int MaxLen     = 1024,
  parameter int LenW       = $clog2(MaxLen + 1),
  parameter int NumW       = 16
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic                cfg_valid_i,
  output logic                cfg_ready_o,
  input  logic [LenW-1:0]     cfg_len_i,
  input  logic [NumW-1:0]     cfg_num_i,
  input  logic                s_valid_i,
  output logic                s_ready_o,
  input  logic [WidthX-1:0]   s_x_i,
  input  logic [WidthK-1:0]   s_k_i,
  output logic                m_valid_o,
  input  logic                m_ready_i,
  output logic [WidthAcc-1:0] m_data_o,
  output logic                busy_o
);
  localparam int WidthP = WidthX + WidthK;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_e;

  state_e              state_q, state_d;
  logic [LenW-1:0]     len_q, idx_q;
  logic [NumW-1:0]     num_q, vec_q;
  logic                en, cfg_fire, cfg_ok, s_fire, is_last, last_vec, inflight;
  logic                b_vld_q, b_first_q, b_last_q;
  logic [WidthX-1:0]   b_x_q;
  logic [WidthK-1:0]   b_k_q;
  logic [2:0]          sb_q [MulLatency];   // {valid, first, last}
  logic                cap_q [AccLatency];
  logic                cap;
  logic [WidthP-1:0]   prod;
  logic [WidthAcc-1:0] acc_y;
  logic                m_valid_q;
  logic [WidthAcc-1:0] m_data_q;

  // Global stall: a held, unaccepted result freezes the whole pipeline.
  assign en       = !m_valid_q || m_ready_i;
  assign cfg_fire = cfg_valid_i && cfg_ready_o;
  assign cfg_ok   = (cfg_len_i != '0) && (cfg_num_i != '0);
  assign s_fire   = s_valid_i && s_ready_o;
  assign is_last  = (idx_q == len_q - LenW'(1));
  assign last_vec = (vec_q == num_q - NumW'(1));
  assign cap      = cap_q[AccLatency-1];

  always_comb begin
    inflight = b_vld_q || b_last_q;
    for (int i = 0; i < MulLatency; i++) inflight = inflight || sb_q[i][2] || sb_q[i][0];
    for (int i = 0; i < AccLatency; i++) inflight = inflight || cap_q[i];
  end

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) state_q <= IDLE;
    else         state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:  if (cfg_fire && cfg_ok) state_d = RUN;
      RUN:   if (s_fire && is_last && last_vec) state_d = DRAIN;
      DRAIN: if (!inflight && (!m_valid_q || m_ready_i)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cfg_ready_o = (state_q == IDLE);
    s_ready_o   = (state_q == RUN) && en;
    busy_o      = (state_q != IDLE);
  end

  // Job configuration and element/vector counters
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      len_q <= '0;
      num_q <= '0;
      idx_q <= '0;
      vec_q <= '0;
    end else if (cfg_fire && cfg_ok) begin
      len_q <= cfg_len_i;
      num_q <= cfg_num_i;
      idx_q <= '0;
      vec_q <= '0;
    end else if (s_fire) begin
      if (is_last) begin
        idx_q <= '0;
        vec_q <= vec_q + NumW'(1);
      end else begin
        idx_q <= idx_q + LenW'(1);
      end
    end
  end

  // Beat register and sideband delay lines. Cycles without a handshake
  // inject valid=0 so the accumulator holds.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      b_vld_q   <= 1'b0;
      b_first_q <= 1'b0;
      b_last_q  <= 1'b0;
      b_x_q     <= '0;
      b_k_q     <= '0;
      for (int i = 0; i < MulLatency; i++) sb_q[i] <= '0;
      for (int i = 0; i < AccLatency; i++) cap_q[i] <= 1'b0;
    end else if (en) begin
      b_vld_q   <= s_fire;
      b_first_q <= s_fire && (idx_q == '0);
      b_last_q  <= s_fire && is_last;
      b_x_q     <= s_x_i;
      b_k_q     <= s_k_i;
      sb_q[0]   <= {b_vld_q, b_first_q, b_last_q};
      for (int i = 1; i < MulLatency; i++) sb_q[i] <= sb_q[i-1];
      cap_q[0]  <= sb_q[MulLatency-1][0];
      for (int i = 1; i < AccLatency; i++) cap_q[i] <= cap_q[i-1];
    end
  end

  mac_ctrl_mul #(
    .WidthX(WidthX), .WidthK(WidthK), .MulLatency(MulLatency), .WidthP(WidthP)
  ) u_mul (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en),
    .x_i(b_x_q), .k_i(b_k_q), .p_o(prod)
  );

  mac_ctrl_acc #(
    .WidthP(WidthP), .WidthAcc(WidthAcc), .AccLatency(AccLatency)
  ) u_acc (
    .clk_i(clk_i), .rst_ni(rst_ni), .en_i(en),
    .x_valid_i(sb_q[MulLatency-1][2]), .first_i(sb_q[MulLatency-1][1]),
    .x_i(prod), .y_o(acc_y)
  );

  // Output register: a capture coinciding with an accept replaces the result
  // and keeps valid high.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
    end else if (en && cap) begin
      m_valid_q <= 1'b1;
      m_data_q  <= acc_y;
    end else if (m_valid_q && m_ready_i) begin
      m_valid_q <= 1'b0;
    end
  end

  assign m_valid_o = m_valid_q;
  assign m_data_o  = m_data_q;
endmodule

// File: tb/tb_mac_ctrl.sv
module tb_mac_ctrl;
  localparam int WX = 4;
  localparam int WK = 8;
  localparam int WA = 20;
  localparam int LW = 11;
  localparam int NW = 16;
  localparam int BUDGET = 200;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          cfg_valid_i;
  logic          cfg_ready_o;
  logic [LW-1:0] cfg_len_i;
  logic [NW-1:0] cfg_num_i;
  logic          s_valid_i;
  logic          s_ready_o;
  logic [WX-1:0] s_x_i;
  logic [WK-1:0] s_k_i;
  logic          m_valid_o;
  logic          m_ready_i;
  logic [WA-1:0] m_data_o;
  logic          busy_o;

  int checks = 0;
  int errors = 0;
  int waits  = 0;
  int xs [8];
  int ks [8];
  logic [WA-1:0] exp_q [$];

  mac_ctrl dut (
    .clk_i(clk), .rst_ni(rst_ni),
    .cfg_valid_i(cfg_valid_i), .cfg_ready_o(cfg_ready_o),
    .cfg_len_i(cfg_len_i), .cfg_num_i(cfg_num_i),
    .s_valid_i(s_valid_i), .s_ready_o(s_ready_o),
    .s_x_i(s_x_i), .s_k_i(s_k_i),
    .m_valid_o(m_valid_o), .m_ready_i(m_ready_i), .m_data_o(m_data_o),
    .busy_o(busy_o)
  );

  // Clock
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s obs=%0d exp=%0d", tag, obs, exp);
    end
  endtask

  task automatic timeout(input string tag);
    checks++;
    errors++;
    $error("FAIL %s obs=timeout exp=event", tag);
  endtask

  // Scoreboard: every accepted result is compared with the oldest expectation.
  always @(negedge clk) begin
    if (rst_ni && m_valid_o && m_ready_i) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $error("FAIL out_extra obs=%0d exp=none", $signed(m_data_o));
      end else begin
        logic [WA-1:0] e;
        e = exp_q.pop_front();
        assert (m_data_o === e) else begin
          errors++;
          $error("FAIL out_data obs=%0d exp=%0d", $signed(m_data_o), $signed(e));
        end
      end
    end
  end

  // Drivers
  task automatic do_cfg(input int len, input int num);
    int n = 0;
    cfg_valid_i = 1'b1;
    cfg_len_i   = LW'(len);
    cfg_num_i   = NW'(num);
    @(negedge clk);
    while (!cfg_ready_o && n < BUDGET) begin @(negedge clk); n++; end
    if (!cfg_ready_o) timeout("cfg_wait");
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
  endtask

  task automatic beat(input int x, input int k);
    int n = 0;
    s_valid_i = 1'b1;
    s_x_i     = x[WX-1:0];
    s_k_i     = k[WK-1:0];
    @(negedge clk);
    if (!s_ready_o) waits++;
    while (!s_ready_o && n < BUDGET) begin @(negedge clk); n++; end
    if (!s_ready_o) timeout("beat_wait");
    @(posedge clk); #1;
    s_valid_i = 1'b0;
  endtask

  task automatic send_vecs(input int len, input int num, input bit bub);
    int sum;
    for (int v = 0; v < num; v++) begin
      sum = 0;
      for (int e = 0; e < len; e++) sum += xs[v*len+e] * ks[v*len+e];
      exp_q.push_back(sum[WA-1:0]);
      for (int e = 0; e < len; e++) begin
        beat(xs[v*len+e], ks[v*len+e]);
        if (bub) begin @(posedge clk); #1; end
      end
    end
  endtask

  task automatic send_job(input int len, input int num, input bit bub);
    do_cfg(len, num);
    send_vecs(len, num, bub);
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while ((busy_o || exp_q.size() != 0) && n < BUDGET) begin @(posedge clk); #1; n++; end
    if (busy_o || exp_q.size() != 0) timeout(tag);
  endtask

  initial begin
    rst_ni = 1'b0; cfg_valid_i = 1'b0; cfg_len_i = '0; cfg_num_i = '0;
    s_valid_i = 1'b0; s_x_i = '0; s_k_i = '0; m_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_cfg_ready", 32'(cfg_ready_o), 1);
    check("rst_s_ready", 32'(s_ready_o), 0);
    check("rst_m_valid", 32'(m_valid_o), 0);
    check("rst_m_data", $signed(m_data_o), 0);
    check("rst_busy", 32'(busy_o), 0);
    rst_ni = 1'b1;

    // Basic dot product and result latency
    xs = '{1, 2, 3, 4, 0, 0, 0, 0};
    ks = '{1, 1, 1, 1, 0, 0, 0, 0};
    do_cfg(4, 1);
    check("cfg_busy", 32'(busy_o), 1);
    check("cfg_s_ready", 32'(s_ready_o), 1);
    send_vecs(4, 1, 1'b0);
    check("lat_t0", 32'(m_valid_o), 0);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      check("lat_early", 32'(m_valid_o), 0);
    end
    @(posedge clk); #1;
    check("lat_t3_valid", 32'(m_valid_o), 1);
    check("lat_t3_data", $signed(m_data_o), 10);
    check("lat_t3_busy", 32'(busy_o), 1);
    @(posedge clk); #1;
    check("busy_drop", 32'(busy_o), 0);
    wait_idle("idle_1");

    // Signed extremes
    xs = '{-8, 0, 0, 0, 0, 0, 0, 0};
    ks = '{-128, 0, 0, 0, 0, 0, 0, 0};
    send_job(1, 1, 1'b0);
    xs = '{-8, -8, 0, 0, 0, 0, 0, 0};
    ks = '{127, 127, 0, 0, 0, 0, 0, 0};
    send_job(2, 1, 1'b0);
    wait_idle("idle_2");

    // Back-to-back vectors at full throughput
    xs = '{2, 3, 4, 1, -1, 0, 0, 0};
    ks = '{1, 1, 2, 1, 5, 7, 0, 0};
    waits = 0;
    send_job(2, 3, 1'b0);
    check("b2b_no_stall", waits, 0);
    wait_idle("idle_3");

    // Backpressure: hold the first result for 10 cycles
    fork
      send_job(2, 3, 1'b0);
      begin
        int n = 0;
        while (!m_valid_o && n < BUDGET) begin @(posedge clk); #1; n++; end
        if (!m_valid_o) timeout("bp_wait");
        m_ready_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
          @(negedge clk);
          check("bp_s_ready", 32'(s_ready_o), 0);
          check("bp_hold_data", $signed(m_data_o), $signed(exp_q[0]));
          @(posedge clk); #1;
        end
        m_ready_i = 1'b1;
      end
    join
    wait_idle("idle_4");

    // Bubbles between beats
    send_job(2, 3, 1'b1);
    wait_idle("idle_5");

    // Zero-length and zero-count configurations are swallowed
    do_cfg(0, 5);
    check("len0_busy", 32'(busy_o), 0);
    check("len0_cfg_ready", 32'(cfg_ready_o), 1);
    do_cfg(3, 0);
    check("num0_busy", 32'(busy_o), 0);

    // Configuration offered during RUN is ignored
    xs = '{5, -3, 0, 0, 0, 0, 0, 0};
    ks = '{6, 4, 0, 0, 0, 0, 0, 0};
    do_cfg(2, 1);
    cfg_valid_i = 1'b1; cfg_len_i = LW'(1); cfg_num_i = NW'(5);
    @(negedge clk);
    check("run_cfg_ready", 32'(cfg_ready_o), 0);
    @(posedge clk); #1;
    cfg_valid_i = 1'b0;
    send_vecs(2, 1, 1'b0);
    wait_idle("idle_6");

    // Reset in the middle of a vector
    do_cfg(4, 1);
    beat(7, 7);
    beat(6, 6);
    rst_ni = 1'b0;
    @(posedge clk); #1;
    check("mid_rst_m_valid", 32'(m_valid_o), 0);
    check("mid_rst_busy", 32'(busy_o), 0);
    check("mid_rst_cfg_ready", 32'(cfg_ready_o), 1);
    rst_ni = 1'b1;
    xs = '{3, 0, 0, 0, 0, 0, 0, 0};
    ks = '{5, 0, 0, 0, 0, 0, 0, 0};
    send_job(1, 1, 1'b0);
    wait_idle("idle_7");

    check("queue_empty", exp_q.size(), 0);
    check("final_busy", 32'(busy_o), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
